// File: rtl/cbfp_bitrev_reorder.sv
// Ping-pong bit-reversal reorder stage following CBFP normalisation.
// Optional sop_out port is enabled by defining CBFP_REORDER_SOP_EN.
module cbfp_bitrev_reorder #(
  parameter int unsigned DATA_W = 13,
  parameter int unsigned LANES  = 16,
  parameter int unsigned BLOCK  = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_in,
  input  logic signed [DATA_W-1:0] data_re_in  [LANES],
  input  logic signed [DATA_W-1:0] data_im_in  [LANES],
  output logic signed [DATA_W-1:0] data_re_out [LANES],
  output logic signed [DATA_W-1:0] data_im_out [LANES],
  output logic                     valid_out
`ifdef CBFP_REORDER_SOP_EN
  ,
  output logic                     sop_out
`endif
);

  localparam int unsigned BEATS = BLOCK / LANES;
  localparam int unsigned AW    = $clog2(BLOCK);
  localparam int unsigned LW    = $clog2(LANES);
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [0:0] {StIdle, StDrain} state_e;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(AW); i++) begin
      r[i] = a[AW-1-i];
    end
    return r;
  endfunction

  // Both banks share one array; the bank select is the address MSB.
  logic signed [DATA_W-1:0] mem_re [2*BLOCK];
  logic signed [DATA_W-1:0] mem_im [2*BLOCK];

  state_e        state_q;
  logic [CW-1:0] wr_cnt_q;
  logic [CW-1:0] rd_cnt_q;
  logic          wr_bank_q;
  logic          rd_bank_q;
  logic          blk_done;
  logic          rd_last;

  assign blk_done = valid_in && (wr_cnt_q == CW'(BEATS - 1));
  assign rd_last  = (rd_cnt_q == CW'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (valid_in) begin
      for (int l = 0; l < int'(LANES); l++) begin
        mem_re[{wr_bank_q, wr_cnt_q, LW'(l)}] <= data_re_in[l];
        mem_im[{wr_bank_q, wr_cnt_q, LW'(l)}] <= data_im_in[l];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      valid_out <= 1'b0;
`ifdef CBFP_REORDER_SOP_EN
      sop_out   <= 1'b0;
`endif
      for (int l = 0; l < int'(LANES); l++) begin
        data_re_out[l] <= '0;
        data_im_out[l] <= '0;
      end
    end else begin
      valid_out <= (state_q == StDrain);
`ifdef CBFP_REORDER_SOP_EN
      sop_out   <= (state_q == StDrain) && (rd_cnt_q == '0);
`endif
      if (state_q == StDrain) begin
        for (int l = 0; l < int'(LANES); l++) begin
          data_re_out[l] <= mem_re[{rd_bank_q, bitrev({rd_cnt_q, LW'(l)})}];
          data_im_out[l] <= mem_im[{rd_bank_q, bitrev({rd_cnt_q, LW'(l)})}];
        end
        rd_cnt_q <= rd_last ? '0 : rd_cnt_q + 1'b1;
        if (rd_last) begin
          state_q <= StIdle;
        end
      end

      if (valid_in) begin
        wr_cnt_q <= blk_done ? '0 : wr_cnt_q + 1'b1;
      end

      // A completing block always (re)starts a drain, overriding the idle transition.
      if (blk_done) begin
        wr_bank_q <= ~wr_bank_q;
        rd_bank_q <= wr_bank_q;
        rd_cnt_q  <= '0;
        state_q   <= StDrain;
      end
    end
  end

endmodule

// File: tb/tb_cbfp_bitrev_reorder.sv
// Self-checking bench for cbfp_bitrev_reorder: block-level reference model plus directed tables.
module tb_cbfp_bitrev_reorder;

  localparam int DW  = 13;
  localparam int NL  = 16;
  localparam int BLK = 64;
  localparam int NB  = BLK / NL;

  typedef logic [NL*DW-1:0] beat_t;
  typedef struct {
    int beat;
    int lane;
    int exp_re;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_in = 1'b0;
  logic signed [DW-1:0] re_in  [NL];
  logic signed [DW-1:0] im_in  [NL];
  logic signed [DW-1:0] re_out [NL];
  logic signed [DW-1:0] im_out [NL];
  logic valid_out;
`ifdef CBFP_REORDER_SOP_EN
  logic sop_out;
`endif

  cbfp_bitrev_reorder #(
    .DATA_W (DW),
    .LANES  (NL),
    .BLOCK  (BLK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_in    (valid_in),
    .data_re_in  (re_in),
    .data_im_in  (im_in),
    .data_re_out (re_out),
    .data_im_out (im_out),
    .valid_out   (valid_out)
`ifdef CBFP_REORDER_SOP_EN
    ,
    .sop_out     (sop_out)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: collect whole blocks, emit bit-reversed beats one per cycle.
  int    blk_re [BLK];
  int    blk_im [BLK];
  int    fill = 0;
  beat_t pend_re [$];
  beat_t pend_im [$];
  bit    pend_sop [$];
  beat_t exp_re = '0;
  beat_t exp_im = '0;
  bit    exp_valid = 1'b0;
  bit    exp_sop = 1'b0;

  beat_t log_re [$];
  beat_t log_im [$];
  int    log_cyc [$];

  function automatic int rev_idx(int n);
    int r = 0;
    int v = n;
    for (int m = BLK; m > 1; m = m / 2) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  function automatic int lane_of(beat_t b, int l);
    logic signed [DW-1:0] v;
    v = b[l*DW +: DW];
    return int'(v);
  endfunction

  task automatic chk(input string nm, input beat_t got, input beat_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d: got %h expected %h", nm, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    beat_t br, bi;
    if (!rst_n) begin
      pend_re.delete();
      pend_im.delete();
      pend_sop.delete();
      fill = 0;
      exp_re = '0;
      exp_im = '0;
      exp_valid = 1'b0;
      exp_sop = 1'b0;
      return;
    end
    if (pend_re.size() > 0) begin
      exp_re = pend_re.pop_front();
      exp_im = pend_im.pop_front();
      exp_sop = pend_sop.pop_front();
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
      exp_sop = 1'b0;
    end
    if (valid_in) begin
      for (int l = 0; l < NL; l++) begin
        blk_re[fill*NL + l] = int'(re_in[l]);
        blk_im[fill*NL + l] = int'(im_in[l]);
      end
      fill++;
      if (fill == NB) begin
        fill = 0;
        for (int b = 0; b < NB; b++) begin
          for (int l = 0; l < NL; l++) begin
            br[l*DW +: DW] = DW'(blk_re[rev_idx(b*NL + l)]);
            bi[l*DW +: DW] = DW'(blk_im[rev_idx(b*NL + l)]);
          end
          pend_re.push_back(br);
          pend_im.push_back(bi);
          pend_sop.push_back(b == 0);
        end
      end
    end
  endtask

  task automatic compare();
    beat_t gr, gi;
    for (int l = 0; l < NL; l++) begin
      gr[l*DW +: DW] = re_out[l];
      gi[l*DW +: DW] = im_out[l];
    end
    chk("valid_out", beat_t'(valid_out), beat_t'(exp_valid));
    chk("data_re_out", gr, exp_re);
    chk("data_im_out", gi, exp_im);
`ifdef CBFP_REORDER_SOP_EN
    chk("sop_out", beat_t'(sop_out), beat_t'(exp_sop));
`endif
    if (valid_out) begin
      log_re.push_back(gr);
      log_im.push_back(gi);
      log_cyc.push_back(cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1 compare();
  endtask

  task automatic clear_log();
    log_re.delete();
    log_im.delete();
    log_cyc.delete();
  endtask

  task automatic set_beat(input int off, input int b);
    valid_in = 1'b1;
    for (int l = 0; l < NL; l++) begin
      re_in[l] = DW'(off + b*NL + l);
      im_in[l] = DW'(-(off + b*NL + l));
    end
  endtask

  task automatic drive_block(input int off);
    for (int b = 0; b < NB; b++) begin
      set_beat(off, b);
      step();
    end
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    vec_t tbl [12];
    int   last;
    int   c4;

    tbl[0]  = '{0, 0, 0};
    tbl[1]  = '{0, 1, 32};
    tbl[2]  = '{0, 2, 16};
    tbl[3]  = '{0, 3, 48};
    tbl[4]  = '{0, 4, 8};
    tbl[5]  = '{0, 15, 60};
    tbl[6]  = '{1, 0, 2};
    tbl[7]  = '{2, 0, 1};
    tbl[8]  = '{3, 0, 3};
    tbl[9]  = '{3, 1, 35};
    tbl[10] = '{3, 2, 19};
    tbl[11] = '{3, 15, 63};

    for (int l = 0; l < NL; l++) begin
      re_in[l] = '0;
      im_in[l] = '0;
    end

    // Reset held with random traffic: outputs must stay zero.
    for (int i = 0; i < 10; i++) begin
      valid_in = 1'($urandom_range(0, 1));
      for (int l = 0; l < NL; l++) begin
        re_in[l] = DW'($urandom);
        im_in[l] = DW'($urandom);
      end
      step();
    end
    rst_n = 1'b1;
    clear_log();
    for (int b = 0; b < NB - 1; b++) begin
      set_beat(0, b);
      step();
    end
    idle(6);
    chk("no_out_before_4_beats", beat_t'(log_re.size()), beat_t'(0));
    set_beat(0, NB - 1);
    step();
    idle(6);
    chk("out_after_4th_beat", beat_t'(log_re.size()), beat_t'(NB));

    // Single block with table-driven lane checks.
    clear_log();
    drive_block(0);
    last = cyc;
    idle(8);
    chk("single_beats", beat_t'(log_re.size()), beat_t'(NB));
    if (log_cyc.size() == NB) begin
      chk("single_first_cyc", beat_t'(log_cyc[0]), beat_t'(last + 1));
      chk("single_last_cyc", beat_t'(log_cyc[NB-1]), beat_t'(last + NB));
      for (int i = 0; i < 12; i++) begin
        chk("tbl_re", beat_t'(lane_of(log_re[tbl[i].beat], tbl[i].lane)),
            beat_t'(tbl[i].exp_re));
        chk("tbl_im", beat_t'(lane_of(log_im[tbl[i].beat], tbl[i].lane)),
            beat_t'(-tbl[i].exp_re));
      end
    end

    // Streaming: three blocks back-to-back.
    clear_log();
    drive_block(0);
    drive_block(64);
    drive_block(128);
    idle(8);
    chk("stream_beats", beat_t'(log_re.size()), beat_t'(3*NB));
    if (log_cyc.size() == 3*NB) begin
      chk("stream_contig", beat_t'(log_cyc[3*NB-1] - log_cyc[0]), beat_t'(3*NB - 1));
      chk("stream_b1_l0", beat_t'(lane_of(log_re[4], 0)), beat_t'(64));
      chk("stream_b2_l1", beat_t'(lane_of(log_re[8], 1)), beat_t'(160));
      chk("stream_b2_im15", beat_t'(lane_of(log_im[11], 15)), beat_t'(-191));
    end

    // Gapped input: alternate valid and idle cycles over two blocks.
    clear_log();
    c4 = 0;
    for (int i = 0; i < 2*NB; i++) begin
      set_beat((i / NB) * 64, i % NB);
      step();
      if (i == NB - 1) c4 = cyc;
      valid_in = 1'b0;
      step();
    end
    idle(6);
    chk("gap_beats", beat_t'(log_re.size()), beat_t'(2*NB));
    if (log_cyc.size() == 2*NB) begin
      chk("gap_first_cyc", beat_t'(log_cyc[0]), beat_t'(c4 + 1));
      chk("gap_b1_l1", beat_t'(lane_of(log_re[NB], 1)), beat_t'(96));
    end

    // Reset mid-drain must clear outputs asynchronously.
    drive_block(200);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", beat_t'(valid_out), beat_t'(0));
    chk("async_rst_data", beat_t'(lane_of(beat_t'(re_out[0]), 0)), beat_t'(0));
    step();
    rst_n = 1'b1;

    // Reset after a partial block: only the new block is emitted.
    clear_log();
    set_beat(0, 0);
    step();
    set_beat(0, 1);
    step();
    valid_in = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive_block(100);
    idle(6);
    chk("midrst_beats", beat_t'(log_re.size()), beat_t'(NB));
    if (log_re.size() == NB) begin
      chk("midrst_b0_l1", beat_t'(lane_of(log_re[0], 1)), beat_t'(132));
    end

    // Random traffic with occasional reset, checked against the model every cycle.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        valid_in = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      valid_in = ($urandom_range(0, 3) != 0);
      for (int l = 0; l < NL; l++) begin
        re_in[l] = DW'($urandom);
        im_in[l] = DW'($urandom);
      end
      step();
    end
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
